// File: rtl/arith_sequencer.sv
// arith_sequencer: multi-cycle add/sub/shift-and-add multiply sharing one N-bit adder
module arith_sequencer #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] result,
  output logic           carry,
  output logic           err
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ADDSUB = 2'd1;
  localparam logic [1:0] MUL    = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;
  logic [1:0]     state_q, state_d;
  logic           sub_q, sub_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [2*N-1:0] p_q, p_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] result_q, result_d;
  logic           carry_q, carry_d, err_q, err_d, busy_q, busy_d, done_q, done_d;
  logic [N-1:0]   add_x, add_y, add_s;
  logic           add_cin, add_co, accept;
  assign accept = start && (state_q == IDLE || state_q == DONE);
  // shared adder: upper product half plus gated multiplicand in MUL, A +/- B otherwise
  always_comb begin
    add_x   = (state_q == MUL) ? p_q[2*N-1:N] : a_q;
    add_y   = (state_q == MUL) ? (p_q[0] ? a_q : '0) : (sub_q ? ~b_q : b_q);
    add_cin = (state_q != MUL) && sub_q;
    {add_co, add_s} = {1'b0, add_x} + {1'b0, add_y} + {{N{1'b0}}, add_cin};
  end
  // sequencing, operand capture and result update
  always_comb begin
    state_d  = state_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    err_d    = err_q;
    if (accept) begin
      sub_d   = op[0];
      a_d     = a;
      b_d     = b;
      p_d     = {{N{1'b0}}, b};
      cnt_d   = '0;
      err_d   = op == 2'b11;
      state_d = (op == 2'b11) ? DONE : (op[1] ? MUL : ADDSUB);
      if (op == 2'b11) begin
        result_d = '0;
        carry_d  = 1'b0;
      end
    end else if (state_q == ADDSUB) begin
      result_d = {{N{1'b0}}, add_s};
      carry_d  = add_co;
      state_d  = DONE;
    end else if (state_q == MUL) begin
      p_d   = {add_co, add_s, p_q[N-1:1]};
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(N - 1)) begin
        result_d = p_d;
        carry_d  = 1'b0;
        state_d  = DONE;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  // status flags follow the state being entered so they stay registered
  always_comb begin
    busy_d = state_d == ADDSUB || state_d == MUL;
    done_d = state_d == DONE;
  end
  // state registers; reset aborts any operation without a done pulse
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign carry  = carry_q;
  assign err    = err_q;
endmodule

// File: tb/tb_arith_sequencer.sv
// tb_arith_sequencer: randomized and directed checks against an arithmetic reference model
module tb_arith_sequencer;
  localparam int N = 8;
  logic clk = 1'b0;
  logic resetn, start, busy, done, carry, err;
  logic [1:0] op;
  logic [N-1:0] a, b;
  logic [2*N-1:0] result;
  int checks = 0;
  int failures = 0;
  longint prev;
  arith_sequencer #(.N(N)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry(carry), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic void model(input int o, input longint x, input longint y,
                                output longint res, output longint car, output longint er, output int lat);
    longint mask = (longint'(1) << N) - 1;
    er = 0;
    car = 0;
    case (o)
      0: begin res = (x + y) & mask; car = (x + y) >> N; lat = 1; end
      1: begin res = (x - y) & mask; car = (x >= y) ? 1 : 0; lat = 1; end
      2: begin res = x * y; lat = N; end
      default: begin res = 0; er = 1; lat = 0; end
    endcase
  endfunction
  task automatic issue(input int o, input int x, input int y, input int poke);
    longint er_res, er_car, er_err;
    int lat, k;
    model(o, x, y, er_res, er_car, er_err, lat);
    @(negedge clk);
    start = 1'b1; op = 2'(o); a = N'(x); b = N'(y);
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!done && k < 2 * N + 4) begin
      check("busy_run", busy, 1);
      check("hold_res", result, prev);
      check("err_clr", err, 0);
      if (k == poke) begin
        start = 1'b1; op = 2'b00; a = N'($urandom); b = N'($urandom);
      end else start = 1'b0;
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    check("done", done, 1);
    check("latency", k, lat);
    check("busy_done", busy, 0);
    check("result", result, er_res);
    check("carry", carry, er_car);
    check("err", err, er_err);
    prev = er_res;
    @(posedge clk); #1;
    check("done_pulse", done, 0);
  endtask
  initial begin
    resetn = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; prev = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry, 0);
    check("rst_err", err, 0);
    @(negedge clk); resetn = 1'b1;
    issue(0, 4, 4, -1);
    issue(0, 200, 100, -1);
    issue(1, 4, 3, -1);
    issue(1, 3, 4, -1);
    issue(2, 255, 255, -1);
    issue(2, 13, 0, -1);
    issue(2, 12, 11, 3);
    issue(3, 77, 99, -1);
    issue(1, 0, 0, -1);
    issue(0, 255, 1, -1);
    for (int i = 0; i < 40; i++)
      issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            ($urandom_range(0, 3) == 0) ? 0 : -1);
    @(negedge clk);
    start = 1'b1; op = 2'b10; a = 8'd37; b = 8'd201;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_result", result, 0);
    check("abort_carry", carry, 0);
    check("abort_err", err, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("abort_nodone", done, 0);
    end
    @(negedge clk); resetn = 1'b1;
    prev = 0;
    issue(0, 1, 2, -1);
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 8'd5; b = 8'd6;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check("b2b_done", done, (i % 2 == 1) ? 1 : 0);
      check("b2b_busy", busy, (i % 2 == 0) ? 1 : 0);
      if (i >= 1) check("b2b_result", result, 11);
    end
    @(negedge clk); start = 1'b0;
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
